// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: Status/Cause/EPC registers, SYSCALL/ERET
// sequencing and pipeline redirect generation.
// Optional feature macro: CP0_INTR_EN adds the level interrupt input and
// the interrupt entry path (Cause[10] mirrors intr).
module cp0_exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  id_cp0Op,
    input  logic [31:0] id_pc,
    input  logic        stall,
    input  logic        wb_we,
    input  logic [4:0]  wb_cs,
    input  logic [2:0]  wb_sel,
    input  logic [31:0] wb_wdata,
    input  logic [4:0]  rd_cs,
`ifdef CP0_INTR_EN
    input  logic        intr,
`endif
    output logic [31:0] rd_data,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        busy,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc
);

    localparam logic [4:0] CS_STATUS  = 5'd12;
    localparam logic [4:0] CS_CAUSE   = 5'd13;
    localparam logic [4:0] CS_EPC     = 5'd14;
    localparam logic [2:0] OP_ERET    = 3'b100;
    localparam logic [2:0] OP_SYSCALL = 3'b011;
    localparam logic [4:0] EXC_SYS    = 5'd8;
    localparam logic [4:0] EXC_INT    = 5'd0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXC,
        S_RET,
        S_JUMP
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] status_q, status_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] redirect_pc_q;
    logic        wb_hit;
    logic        epc_wr;
    logic        intr_take;
    logic        intr_level;

`ifdef CP0_INTR_EN
    assign intr_level = intr;
    assign intr_take  = intr && status_q[0] && !status_q[1];
`else
    assign intr_level = 1'b0;
    assign intr_take  = 1'b0;
`endif

    assign wb_hit = wb_we && (wb_sel == 3'd0);
    assign epc_wr = wb_hit && (wb_cs == CS_EPC);

    // Next state and next register contents; FSM field updates override WB writes.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        if (wb_hit && wb_cs == CS_STATUS) status_d = wb_wdata;
        if (wb_hit && wb_cs == CS_CAUSE)  cause_d  = wb_wdata;
        if (epc_wr)                       epc_d    = wb_wdata;
        case (state_q)
            S_IDLE: begin
                if (!stall) begin
                    if (id_cp0Op == OP_ERET) begin
                        state_d     = S_RET;
                        status_d[1] = 1'b0;
                    end else if (id_cp0Op == OP_SYSCALL) begin
                        state_d      = S_EXC;
                        epc_d        = id_pc;
                        cause_d[6:2] = EXC_SYS;
                        status_d[1]  = 1'b1;
                    end else if (intr_take) begin
                        state_d      = S_EXC;
                        epc_d        = id_pc;
                        cause_d[6:2] = EXC_INT;
                        status_d[1]  = 1'b1;
                    end
                end
            end
            S_EXC:   state_d = S_JUMP;
            S_RET:   state_d = S_IDLE;
            S_JUMP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        cause_d[10] = intr_level;
    end

    // State, CP0 registers and registered redirect outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            status_q      <= '0;
            cause_q       <= '0;
            epc_q         <= '0;
            busy          <= 1'b0;
            redirect      <= 1'b0;
            flush         <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            busy     <= (state_d != S_IDLE);
            redirect <= (state_d == S_RET) || (state_d == S_JUMP);
            flush    <= (state_d == S_RET) || (state_d == S_JUMP);
            if (state_d == S_JUMP)     redirect_pc_q <= HANDLER_ADDR;
            else if (state_d == S_RET) redirect_pc_q <= epc_d;
            else                       redirect_pc_q <= '0;
        end
    end

    // A WB write to EPC during RET replaces the target that was latched at acceptance.
    assign redirect_pc = (state_q == S_RET && epc_wr) ? wb_wdata : redirect_pc_q;

    assign status = status_q;
    assign cause  = cause_q;
    assign epc    = epc_q;

    // MFC0 read port.
    always_comb begin
        rd_data = '0;
        case (rd_cs)
            CS_STATUS: rd_data = status_q;
            CS_CAUSE:  rd_data = cause_q;
            CS_EPC:    rd_data = epc_q;
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios then random traffic,
// checked by a per-cycle scoreboard fed from a behavioural model.
module tb_cp0_exc_ctrl;

    localparam logic [31:0] HANDLER = 32'h0000_0004;
`ifdef CP0_INTR_EN
    localparam bit INTR = 1'b1;
`else
    localparam bit INTR = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [2:0]  id_cp0Op;
    logic [31:0] id_pc;
    logic        stall;
    logic        wb_we;
    logic [4:0]  wb_cs;
    logic [2:0]  wb_sel;
    logic [31:0] wb_wdata;
    logic [4:0]  rd_cs;
`ifdef CP0_INTR_EN
    logic        intr;
`endif
    logic [31:0] rd_data;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        busy;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;

    cp0_exc_ctrl #(.HANDLER_ADDR(HANDLER)) dut (
        .clk(clk), .rst(rst), .id_cp0Op(id_cp0Op), .id_pc(id_pc), .stall(stall),
        .wb_we(wb_we), .wb_cs(wb_cs), .wb_sel(wb_sel), .wb_wdata(wb_wdata),
        .rd_cs(rd_cs),
`ifdef CP0_INTR_EN
        .intr(intr),
`endif
        .rd_data(rd_data), .flush(flush), .redirect(redirect),
        .redirect_pc(redirect_pc), .busy(busy), .status(status),
        .cause(cause), .epc(epc)
    );

    typedef struct {
        logic        r;
        logic [2:0]  op;
        logic [31:0] pc;
        logic        stl;
        logic        we;
        logic [4:0]  cs;
        logic [2:0]  sel;
        logic [31:0] wd;
        logic [4:0]  rcs;
        logic        irq;
    } stim_t;

    typedef struct {
        logic [31:0] st;
        logic [31:0] ca;
        logic [31:0] ep;
        logic [31:0] rd;
        logic [31:0] rpc;
        logic        bsy;
        logic        rdr;
        logic        fl;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    // Model state: architectural registers plus the list of upcoming busy cycles.
    // Plan entries: 0 = busy without redirect, 1 = redirect to handler, 2 = return to EPC.
    logic [31:0] m_st = '0, m_ca = '0, m_epc = '0;
    int          plan[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t nop();
        stim_t s;
        s.r = 1'b0; s.op = 3'b000; s.pc = 32'h0; s.stl = 1'b0; s.we = 1'b0;
        s.cs = 5'd0; s.sel = 3'd0; s.wd = 32'h0; s.rcs = 5'd14; s.irq = 1'b0;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle: push the model's view of this cycle, drive inputs, advance the model.
    task automatic step(input stim_t s);
        exp_t        e;
        logic        wepc;
        logic        bsy;
        logic [31:0] ns, nc, ne;
        @(negedge clk);
        if (s.r) begin
            m_st = '0; m_ca = '0; m_epc = '0;
            plan.delete();
        end
        wepc  = s.we && s.sel == 3'd0 && s.cs == 5'd14;
        bsy   = plan.size() != 0;
        e.st  = m_st;
        e.ca  = m_ca;
        e.ep  = m_epc;
        e.rd  = (s.rcs == 5'd12) ? m_st : (s.rcs == 5'd13) ? m_ca : (s.rcs == 5'd14) ? m_epc : 32'h0;
        e.bsy = bsy;
        e.rdr = bsy && plan[0] != 0;
        e.fl  = e.rdr;
        e.rpc = !e.rdr ? 32'h0 : (plan[0] == 1) ? HANDLER : (wepc ? s.wd : m_epc);
        sbq.push_back(e);

        rst = s.r; id_cp0Op = s.op; id_pc = s.pc; stall = s.stl; wb_we = s.we;
        wb_cs = s.cs; wb_sel = s.sel; wb_wdata = s.wd; rd_cs = s.rcs;
`ifdef CP0_INTR_EN
        intr = s.irq;
`endif

        if (!s.r) begin
            ns = m_st; nc = m_ca; ne = m_epc;
            if (s.we && s.sel == 3'd0) begin
                if (s.cs == 5'd12) ns = s.wd;
                if (s.cs == 5'd13) nc = s.wd;
                if (s.cs == 5'd14) ne = s.wd;
            end
            if (plan.size() != 0) begin
                void'(plan.pop_front());
            end else if (!s.stl) begin
                if (s.op == 3'b100) begin
                    ns[1] = 1'b0;
                    plan.push_back(2);
                end else if (s.op == 3'b011) begin
                    ne = s.pc; nc[6:2] = 5'd8; ns[1] = 1'b1;
                    plan.push_back(0); plan.push_back(1);
                end else if (INTR && s.irq && m_st[0] && !m_st[1]) begin
                    ne = s.pc; nc[6:2] = 5'd0; ns[1] = 1'b1;
                    plan.push_back(0); plan.push_back(1);
                end
            end
            nc[10] = INTR ? s.irq : 1'b0;
            m_st = ns; m_ca = nc; m_epc = ne;
        end
    endtask

    // Monitor: compare every cycle's outputs against the next scoreboard entry.
    initial begin
        exp_t e;
        while (!done) begin
            @(negedge clk);
            #2;
            if (done) break;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
            end else begin
                e = sbq.pop_front();
                chk("status", status, e.st);
                chk("cause", cause, e.ca);
                chk("epc", epc, e.ep);
                chk("rd_data", rd_data, e.rd);
                chk("redirect_pc", redirect_pc, e.rpc);
                chk("busy", 32'(busy), 32'(e.bsy));
                chk("redirect", 32'(redirect), 32'(e.rdr));
                chk("flush", 32'(flush), 32'(e.fl));
            end
        end
    end

    initial begin
        stim_t s;
        rst = 1'b1; id_cp0Op = '0; id_pc = '0; stall = 1'b0; wb_we = 1'b0;
        wb_cs = '0; wb_sel = '0; wb_wdata = '0; rd_cs = '0;
`ifdef CP0_INTR_EN
        intr = 1'b0;
`endif
        s = nop(); s.r = 1'b1;
        step(s); step(s);

        // SYSCALL at 0x40: EPC/Cause/EXL next cycle, handler redirect after.
        s = nop(); s.op = 3'b011; s.pc = 32'h40; step(s);
        s = nop(); s.rcs = 5'd13; step(s); step(s); step(s);

        // ERET to EPC=0x100.
        s = nop(); s.we = 1'b1; s.cs = 5'd14; s.wd = 32'h100; step(s);
        s = nop(); s.op = 3'b100; step(s);
        s = nop(); step(s); step(s);

        // ERET with simultaneous EPC write 0x200.
        s = nop(); s.op = 3'b100; s.we = 1'b1; s.cs = 5'd14; s.wd = 32'h200; step(s);
        s = nop(); step(s); step(s);

        // ERET followed by an EPC write during RET.
        s = nop(); s.op = 3'b100; step(s);
        s = nop(); s.we = 1'b1; s.cs = 5'd14; s.wd = 32'h300; step(s);
        s = nop(); step(s);

        // SYSCALL held off by stall for 3 cycles.
        s = nop(); s.op = 3'b011; s.pc = 32'h500; s.stl = 1'b1;
        step(s); step(s); step(s);
        s.stl = 1'b0; step(s);
        s = nop(); step(s); step(s); step(s);

        // Reset pulsed in EXC aborts the sequence.
        s = nop(); s.op = 3'b011; s.pc = 32'h60; step(s);
        s = nop(); s.r = 1'b1; step(s);
        s = nop(); step(s); step(s); step(s); step(s);

        // Interrupt entry with IE=1, then ignored while EXL=1.
        s = nop(); s.we = 1'b1; s.cs = 5'd12; s.wd = 32'h1; step(s);
        s = nop(); s.irq = 1'b1; s.pc = 32'h80; step(s);
        s = nop(); s.irq = 1'b1; step(s); step(s); step(s); step(s);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            s.r   = ($urandom_range(99) == 0);
            s.op  = 3'($urandom_range(7));
            s.pc  = $urandom & 32'hFFFF_FFFC;
            s.stl = ($urandom_range(3) == 0);
            s.we  = ($urandom_range(2) == 0);
            s.cs  = 5'($urandom_range(15, 11));
            s.sel = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : 3'd0;
            s.wd  = $urandom;
            s.rcs = 5'($urandom_range(15, 11));
            s.irq = ($urandom_range(2) == 0);
            step(s);
        end
        s = nop();
        step(s);

        #3;
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 SHALL have parameter HANDLER_ADDR, default 32'h0000_0004, the exception handler entry PC.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have port id_cp0Op, input, 3, ID-stage op: 3'b100 ERET, 3'b010 MTC0, 3'b011 SYSCALL, other values no-op.
REQ-005 SHALL have port id_pc, input, 32, PC of the ID-stage instruction.
REQ-006 SHALL have port stall, input, 1, pipeline stall; while high, no new request is accepted.
REQ-007 SHALL have ports wb_we (input, 1), wb_cs (input, 5), wb_sel (input, 3), wb_wdata (input, 32): the MTC0 write from WB.
REQ-008 SHALL have ports rd_cs (input, 5) and rd_data (output, 32): MFC0 combinational read.
REQ-009 SHALL have port intr, input, 1, level external interrupt; present only with CP0_INTR_EN.
REQ-010 SHALL have outputs flush (1), redirect (1), redirect_pc (32), busy (1), status (32), cause (32), epc (32).

Function
REQ-011 SHALL implement Status (cs 12), Cause (cs 13), EPC (cs 14), all sel 0; Status[0]=IE, Status[1]=EXL, Cause[6:2]=ExcCode.
REQ-012 SHALL write a register when wb_we=1 and cs/sel match; other cs/sel writes ignored; rd_data = 0 for unmapped cs.
REQ-013 SHALL implement FSM states IDLE, EXC, RET, JUMP.
REQ-014 SHALL accept a request only in IDLE with stall=0; priority ERET > SYSCALL > interrupt.
REQ-015 IDLE->EXC on SYSCALL: in the next cycle EPC<=id_pc, Cause[6:2]<=8, EXL<=1.
REQ-016 EXC->JUMP unconditionally; in JUMP, redirect=1, redirect_pc=HANDLER_ADDR, flush=1 for exactly one cycle; JUMP->IDLE.
REQ-017 IDLE->RET on ERET; in RET, redirect=1, flush=1, redirect_pc=EPC, EXL<=0; RET->IDLE.
REQ-018 ERET latency: redirect one cycle after acceptance; SYSCALL/interrupt latency: redirect two cycles after acceptance.
REQ-019 If a WB write to EPC occurs in the same cycle an ERET is accepted or in RET, redirect_pc SHALL use wb_wdata (bypass), and the register is also updated.
REQ-020 SHALL give a WB write to Status/Cause/EPC priority over a no-op cycle, but the FSM's own update in EXC/RET wins for fields it writes (EPC, ExcCode, EXL).
REQ-021 busy SHALL be 1 in every state except IDLE; id_cp0Op ignored while busy.
REQ-022 flush and redirect SHALL be 0 in IDLE and EXC.
REQ-023 status/cause/epc outputs SHALL reflect register contents with no added latency.

Reset
REQ-024 On rst=1, asynchronously: state=IDLE, Status=0, Cause=0, EPC=0, flush=0, redirect=0, redirect_pc=0, busy=0.
REQ-025 rst asserted in EXC, RET or JUMP SHALL abort the sequence with no redirect emitted after release.
REQ-026 First request accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 With CP0_INTR_EN defined: intr=1 with IE=1, EXL=0 in IDLE (no higher-priority request, stall=0) enters EXC with EPC<=id_pc, ExcCode<=0, Cause[10]<=1 (mirrors intr each cycle).
REQ-028 Without CP0_INTR_EN: no intr port, Cause[10] reads 0, interrupt path absent.

Verification
REQ-029 SYSCALL at id_pc=32'h0000_0040 -> next cycle EPC=32'h40, cause=32'h20, status[1]=1; following cycle redirect=1, redirect_pc=32'h4, flush=1.
REQ-030 EPC=32'h100, ERET -> next cycle redirect=1, redirect_pc=32'h100, status[1]=0.
REQ-031 ERET with simultaneous wb_we=1, wb_cs=14, wb_wdata=32'h200 -> redirect_pc=32'h200, epc=32'h200.
REQ-032 SYSCALL while stall=1 for 3 cycles -> busy stays 0, no EPC change; accepted on first cycle stall=0.
REQ-033 rst pulsed in EXC after SYSCALL -> all outputs 0, no redirect in following 4 cycles.
REQ-034 CP0_INTR_EN: Status=32'h1, intr=1, id_pc=32'h80 -> EPC=32'h80, cause=32'h400, redirect_pc=32'h4; with EXL=1 intr ignored.
